// File: rtl/sphere_motor_pkg.sv
// sphere_motor_pkg: shared stepper FSM type and coil phase tables; HALF_STEP_EN selects half-step mode
package sphere_motor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [3:0][3:0] FULL_TBL = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
  localparam logic [7:0][3:0] HALF_TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                          4'b0110, 4'b0010, 4'b0011, 4'b0001};
`ifdef HALF_STEP_EN
  localparam int TBL_LEN = 8;
  localparam int IDX_W = 3;
`else
  localparam int TBL_LEN = 4;
  localparam int IDX_W = 2;
`endif
  // Table lengths are powers of two, so an IDX_W-bit index wraps modulo TBL_LEN for free
  function automatic logic [3:0] phase_pattern(input logic [IDX_W-1:0] idx);
`ifdef HALF_STEP_EN
    return HALF_TBL[idx];
`else
    return FULL_TBL[idx];
`endif
  endfunction
endpackage

// File: rtl/step_edge_detect.sv
// step_edge_detect: one-cycle pulse on each rising edge of a same-domain divided clock
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);
  logic prev_q;
  always_ff @(posedge clk) prev_q <= rst ? 1'b0 : sig_i;
  assign rise_o = sig_i & ~prev_q;
endmodule

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer: relative-move stepper coil sequencer driven by step_clk edges; HALF_STEP_EN selects half-step table
module stepper_phase_sequencer
  import sphere_motor_pkg::*;
#(
  parameter int STEP_CNT_W = 16,
  parameter int POS_W      = 32
) (
  input  logic                    input_clk,
  input  logic                    reset,
  input  logic                    step_clk,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEP_CNT_W-1:0]   cmd_steps,
  input  logic                    abort,
  output logic [3:0]              coil_out,
  output logic                    busy,
  output logic                    done,
  output logic [STEP_CNT_W-1:0]   steps_left,
  output logic signed [POS_W-1:0] position
);
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [STEP_CNT_W-1:0]   left_q, left_d;
  logic                    dir_q, dir_d;
  logic [3:0]              coil_q;
  logic                    step_edge;
  step_edge_detect u_edge (
    .clk   (input_clk),
    .rst   (reset),
    .sig_i (step_clk),
    .rise_o(step_edge)
  );
  // Abort outranks a coincident step edge so an aborted move never completes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    left_d  = left_q;
    dir_d   = dir_q;
    if (state_q == IDLE && cmd_valid) begin
      dir_d   = cmd_dir;
      left_d  = cmd_steps;
      state_d = (cmd_steps == '0) ? DONE : RUN;
    end else if (state_q == RUN && abort) begin
      left_d  = '0;
      state_d = IDLE;
    end else if (state_q == RUN && step_edge && enable) begin
      idx_d   = dir_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
      pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      left_d  = left_q - STEP_CNT_W'(1);
      state_d = (left_q == STEP_CNT_W'(1)) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      left_q  <= '0;
      dir_q   <= 1'b0;
      coil_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      left_q  <= left_d;
      dir_q   <= dir_d;
      coil_q  <= enable ? phase_pattern(idx_d) : 4'b0000;
    end
  end
  assign cmd_ready  = (state_q == IDLE) && !reset;
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign coil_out   = coil_q;
  assign steps_left = left_q;
  assign position   = pos_q;
endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// tb_stepper_phase_sequencer: directed and randomized checks of the stepper sequencer against a position-based model
module tb_stepper_phase_sequencer;
  logic clk = 1'b0;
  logic rst, step, en, vld, dir, ab;
  logic [15:0] steps;
  logic ready, busy, done;
  logic [3:0] coil;
  logic [15:0] left;
  logic signed [31:0] pos;
  int total = 0;
  int bad = 0;
  bit m_busy, m_done, m_dir, m_en, m_prev;
  int m_left, m_pos;
  logic [3:0] tbl [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

  stepper_phase_sequencer #(.STEP_CNT_W(16), .POS_W(32)) dut (
    .input_clk (clk),
    .reset     (rst),
    .step_clk  (step),
    .enable    (en),
    .cmd_valid (vld),
    .cmd_ready (ready),
    .cmd_dir   (dir),
    .cmd_steps (steps),
    .abort     (ab),
    .coil_out  (coil),
    .busy      (busy),
    .done      (done),
    .steps_left(left),
    .position  (pos)
  );

  always #5 clk = ~clk;

  // Model: coil phase is position mod 4, so no separate index is tracked
  task automatic tick(input logic s);
    bit e, fin;
    step = s;
    e = s && !m_prev;
    m_prev = s;
    fin = 0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_left = 0; m_pos = 0; m_dir = 0; m_en = 0; m_prev = 0;
    end else begin
      if (!m_busy && !m_done && vld) begin
        m_left = int'(steps); m_dir = dir;
        if (steps == 0) fin = 1; else m_busy = 1;
      end else if (m_busy && ab) begin
        m_busy = 0; m_left = 0;
      end else if (m_busy && e && en) begin
        m_pos += m_dir ? 1 : -1;
        m_left--;
        if (m_left == 0) begin m_busy = 0; fin = 1; end
      end
      m_done = fin;
      m_en = en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic d, input logic [15:0] n, input logic s);
    dir = d; steps = n; vld = 1;
    tick(s);
    vld = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; vld = 0; ab = 0; dir = 0; steps = 0;
    tick(0); tick(0);
    total++; if (coil !== 4'b0000) begin bad++; $display("FAIL reset_coil got=%b want=0000", coil); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b want=0,0", busy, done); end
    total++; if (pos !== 0 || left !== 0) begin bad++; $display("FAIL reset_counts pos=%0d left=%0d want=0,0", pos, left); end
    rst = 0;
    tick(0);
    total++; if (coil !== 4'b0011) begin bad++; $display("FAIL hold_coil got=%b want=0011", coil); end
    total++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_ready ready=%b busy=%b want=1,0", ready, busy); end
  endtask

  task automatic test_forward();
    logic [3:0] exp_c [5] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110};
    accept(1, 5, 0);
    total++; if (busy !== 1'b1 || left !== 16'd5) begin bad++; $display("FAIL fwd_accept busy=%b left=%0d want=1,5", busy, left); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      total++; if (coil !== exp_c[i]) begin bad++; $display("FAIL fwd_coil%0d got=%b want=%b", i, coil, exp_c[i]); end
      total++; if (pos !== i + 1 || left !== 16'(4 - i)) begin bad++; $display("FAIL fwd_cnt%0d pos=%0d left=%0d want=%0d,%0d", i, pos, left, i + 1, 4 - i); end
      total++; if (done !== (i == 4)) begin bad++; $display("FAIL fwd_done%0d got=%b want=%b", i, done, i == 4); end
      tick(0);
    end
    total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL fwd_end done=%b ready=%b want=0,1", done, ready); end
  endtask

  task automatic test_reverse();
    logic [3:0] exp_c [3] = '{4'b1001, 4'b1100, 4'b0110};
    rst = 1; tick(0); rst = 0; tick(0);
    accept(0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (coil !== exp_c[i]) begin bad++; $display("FAIL rev_coil%0d got=%b want=%b", i, coil, exp_c[i]); end
      tick(0);
    end
    total++; if (pos !== 32'hFFFF_FFFD) begin bad++; $display("FAIL rev_pos got=%h want=fffffffd", pos); end
  endtask

  task automatic test_enable_pause();
    logic [3:0] exp_c [3] = '{4'b1001, 4'b0011, 4'b0110};
    accept(1, 4, 0);
    tick(1); tick(0);
    total++; if (coil !== 4'b1100 || pos !== -2) begin bad++; $display("FAIL pause_pre coil=%b pos=%0d want=1100,-2", coil, pos); end
    en = 0;
    tick(1); tick(0); tick(1); tick(0);
    total++; if (coil !== 4'b0000) begin bad++; $display("FAIL pause_coil got=%b want=0000", coil); end
    total++; if (left !== 16'd3 || pos !== -2) begin bad++; $display("FAIL pause_cnt left=%0d pos=%0d want=3,-2", left, pos); end
    en = 1;
    tick(0);
    total++; if (coil !== 4'b1100 || busy !== 1'b1) begin bad++; $display("FAIL resume_coil coil=%b busy=%b want=1100,1", coil, busy); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (coil !== exp_c[i] || pos !== i - 1) begin bad++; $display("FAIL resume%0d coil=%b pos=%0d want=%b,%0d", i, coil, pos, exp_c[i], i - 1); end
      tick(0);
    end
  endtask

  task automatic test_zero_steps();
    accept(1, 0, 0);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done done=%b busy=%b want=1,0", done, busy); end
    total++; if (coil !== 4'b0110 || pos !== 1 || left !== 0) begin bad++; $display("FAIL zero_hold coil=%b pos=%0d left=%0d want=0110,1,0", coil, pos, left); end
    tick(0);
    total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL zero_end done=%b ready=%b want=0,1", done, ready); end
  endtask

  task automatic test_abort_final();
    rst = 1; tick(0); rst = 0; tick(0);
    accept(1, 4, 0);
    for (int i = 0; i < 3; i++) begin tick(1); tick(0); end
    ab = 1;
    tick(1);
    ab = 0;
    total++; if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL abort_flags done=%b busy=%b ready=%b want=0,0,1", done, busy, ready); end
    total++; if (pos !== 3 || left !== 0 || coil !== 4'b1001) begin bad++; $display("FAIL abort_state pos=%0d left=%0d coil=%b want=3,0,1001", pos, left, coil); end
    tick(0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_nodone got=%b want=0", done); end
  endtask

  task automatic test_high_at_accept();
    accept(1, 2, 1);
    tick(1); tick(1);
    total++; if (pos !== 3 || left !== 16'd2) begin bad++; $display("FAIL high_nostep pos=%0d left=%0d want=3,2", pos, left); end
    tick(0); tick(1);
    total++; if (pos !== 4 || left !== 16'd1 || coil !== 4'b0011) begin bad++; $display("FAIL high_step pos=%0d left=%0d coil=%b want=4,1,0011", pos, left, coil); end
    tick(0); tick(1);
    total++; if (done !== 1'b1 || pos !== 5) begin bad++; $display("FAIL high_done done=%b pos=%0d want=1,5", done, pos); end
    tick(0);
  endtask

  task automatic test_random();
    logic [3:0] ec;
    rst = 1; tick(0); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      en = ($urandom_range(0, 9) != 0);
      vld = ($urandom_range(0, 3) == 0);
      dir = 1'($urandom_range(0, 1));
      steps = 16'($urandom_range(0, 6));
      ab = ($urandom_range(0, 39) == 0);
      tick(1'($urandom_range(0, 1)));
      ec = m_en ? tbl[m_pos & 3] : 4'b0000;
      total++; if (coil !== ec) begin bad++; $display("FAIL rnd_coil c=%0d got=%b want=%b", c, coil, ec); end
      total++; if (pos !== m_pos) begin bad++; $display("FAIL rnd_pos c=%0d got=%0d want=%0d", c, pos, m_pos); end
      total++; if (left !== 16'(m_left)) begin bad++; $display("FAIL rnd_left c=%0d got=%0d want=%0d", c, left, m_left); end
      total++; if (done !== m_done || busy !== m_busy) begin bad++; $display("FAIL rnd_flags c=%0d done=%b busy=%b want=%b,%b", c, done, busy, m_done, m_busy); end
      total++; if (ready !== (!m_busy && !m_done && !rst)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, ready, !m_busy && !m_done && !rst); end
    end
    rst = 0; vld = 0; ab = 0; en = 1;
  endtask

  initial begin
    rst = 1; step = 0; en = 1; vld = 0; dir = 0; ab = 0; steps = 0;
    m_busy = 0; m_done = 0; m_dir = 0; m_en = 0; m_prev = 0; m_left = 0; m_pos = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_enable_pause();
    test_zero_steps();
    test_abort_final();
    test_high_at_accept();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
